// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: serializes op/a/b onto the ALU start/inbus/outbus/finish protocol; ALU_SEQ_TIMEOUT_EN enables the WAIT timeout
module alu_op_sequencer #(
  parameter int WIDTH = 16,
  parameter int OPW = 4,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [OPW-1:0]   req_op,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_hi,
  output logic [WIDTH-1:0] rsp_lo,
  output logic [3:0]       rsp_flags,
  output logic             rsp_err,
  output logic             alu_rst_b,
  output logic             alu_start,
  output logic [OPW-1:0]   alu_s,
  output logic [WIDTH-1:0] alu_inbus,
  input  logic [WIDTH-1:0] alu_outbus,
  input  logic             alu_finish,
  input  logic             alu_negative,
  input  logic             alu_zero,
  input  logic             alu_carry,
  input  logic             alu_overflow
);
  typedef enum logic [2:0] {IDLE, ARST, SETUP, OPA, OPB, WAIT, CAP1, RESP} state_t;
  state_t state;
  logic [OPW-1:0] op;
  logic [WIDTH-1:0] a, b;
  logic two_word;
`ifdef ALU_SEQ_TIMEOUT_EN
  logic [15:0] cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_hi <= '0;
      rsp_lo <= '0;
      rsp_flags <= '0;
      rsp_err <= 1'b0;
      alu_rst_b <= 1'b1;
      alu_start <= 1'b0;
      alu_s <= '0;
      alu_inbus <= '0;
      op <= '0;
      a <= '0;
      b <= '0;
      two_word <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
      cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (req_valid && req_ready) begin
            op <= req_op;
            a <= req_a;
            b <= req_b;
            two_word <= req_op == OPW'(2) || req_op == OPW'(3);
            req_ready <= 1'b0;
            rsp_err <= 1'b0;
            alu_rst_b <= 1'b0;
            state <= ARST;
          end
        end
        ARST: begin
          alu_rst_b <= 1'b1;
          alu_s <= op;
          state <= SETUP;
        end
        SETUP: begin
          alu_start <= 1'b1;
          alu_inbus <= a;
          state <= OPA;
        end
        OPA: begin
          alu_start <= 1'b0;
          alu_inbus <= b;
          state <= OPB;
        end
        OPB: begin
`ifdef ALU_SEQ_TIMEOUT_EN
          cnt <= '0;
`endif
          state <= WAIT;
        end
        WAIT: begin
          if (alu_finish) begin
            rsp_flags <= {alu_negative, alu_zero, alu_carry, alu_overflow};
            if (two_word) begin
              rsp_hi <= alu_outbus;
              state <= CAP1;
            end else begin
              rsp_hi <= '0;
              rsp_lo <= alu_outbus;
              rsp_valid <= 1'b1;
              state <= RESP;
            end
          end
`ifdef ALU_SEQ_TIMEOUT_EN
          else begin
            cnt <= cnt + 16'd1;
            if (cnt == 16'(TIMEOUT_CYCLES - 1)) begin
              alu_rst_b <= 1'b0;
              rsp_err <= 1'b1;
              rsp_hi <= '0;
              rsp_lo <= '0;
              rsp_flags <= '0;
              rsp_valid <= 1'b1;
              state <= RESP;
            end
          end
`endif
        end
        CAP1: begin
          rsp_lo <= alu_outbus;
          rsp_valid <= 1'b1;
          state <= RESP;
        end
        RESP: begin
          alu_rst_b <= 1'b1;
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
